// File: rtl/l2_port_scheduler.sv
// ---------------------------------------------------------------------------
// l2_port_scheduler
//
// Shares the single L2 cache port among three L1-side requesters: the data
// cache (D), the instruction cache (I) and the instruction prefetcher (PF).
// One request is latched at a time, driven onto the L2 port until l2_resp,
// and the completion pulse is routed back to the request's owner.
//
// Arbitration is fixed priority D > I > PF. A starvation guard forces an
// I grant once STARVE_LIMIT consecutive D grants have been made while the
// I-cache was waiting.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   d_read, d_write, d_addr,
//   d_wdata                      D-cache request (level-held until d_resp)
//   d_rdata, d_resp              D-cache read line / completion pulse
//   i_read, i_addr               I-cache read request (held until i_resp)
//   i_rdata, i_resp              I-cache read line / completion pulse
//   pf_read, pf_addr             prefetcher read request (held until pf_resp)
//   pf_rdata, pf_resp            prefetcher read line / completion pulse
//   l2_read, l2_write, l2_addr,
//   l2_wdata                     registered L2 command
//   l2_rdata, l2_resp            L2 read line / completion pulse
//
// Parameter
//   STARVE_LIMIT                 consecutive D grants (with I pending) that
//                                force the next grant to I; legal 1..15
// ---------------------------------------------------------------------------
module l2_port_scheduler #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic         pf_read,
    input  logic [31:0]  pf_addr,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,

    output logic         l2_read,
    output logic         l2_write,
    output logic [31:0]  l2_addr,
    output logic [255:0] l2_wdata,
    input  logic [255:0] l2_rdata,
    input  logic         l2_resp
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Owner encoding of the latched transaction
    localparam logic [1:0] OWN_D  = 2'd0;
    localparam logic [1:0] OWN_I  = 2'd1;
    localparam logic [1:0] OWN_PF = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]   r_state;
    logic [1:0]   r_owner;
    logic         r_l2_read;
    logic         r_l2_write;
    logic [31:0]  r_l2_addr;
    logic [255:0] r_l2_wdata;
    logic [3:0]   r_starve_cnt;

    // -----------------------------------------------------------------------
    // Arbitration (evaluated every cycle, used only in IDLE)
    // -----------------------------------------------------------------------
    logic         w_grant;
    logic [1:0]   w_gnt_owner;
    logic         w_gnt_write;
    logic [31:0]  w_gnt_addr;
    logic [255:0] w_gnt_wdata;
    logic [3:0]   w_starve_next;
    logic [3:0]   w_starve_inc;
    logic         w_starved;

    // Saturating increment; the counter never exceeds LIMIT.
    assign w_starve_inc = (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
    assign w_starved    = i_read && (r_starve_cnt == LIMIT);

    always_comb begin
        w_grant       = 1'b0;
        w_gnt_owner   = OWN_D;
        w_gnt_write   = 1'b0;
        w_gnt_addr    = d_addr;
        w_gnt_wdata   = '0;
        w_starve_next = r_starve_cnt;

        if (w_starved) begin
            // Starvation guard overrides the D priority.
            w_grant       = 1'b1;
            w_gnt_owner   = OWN_I;
            w_gnt_addr    = i_addr;
            w_starve_next = 4'd0;
        end else if (d_write) begin
            // Write wins over a simultaneous read (that pairing is illegal
            // input, but it must resolve deterministically).
            w_grant       = 1'b1;
            w_gnt_owner   = OWN_D;
            w_gnt_write   = 1'b1;
            w_gnt_addr    = d_addr;
            w_gnt_wdata   = d_wdata;
            w_starve_next = i_read ? w_starve_inc : 4'd0;
        end else if (d_read) begin
            w_grant       = 1'b1;
            w_gnt_owner   = OWN_D;
            w_gnt_addr    = d_addr;
            w_starve_next = i_read ? w_starve_inc : 4'd0;
        end else if (i_read) begin
            w_grant       = 1'b1;
            w_gnt_owner   = OWN_I;
            w_gnt_addr    = i_addr;
            w_starve_next = 4'd0;
        end else if (pf_read) begin
            // Prefetcher is read-only and does not touch the starve counter.
            w_grant       = 1'b1;
            w_gnt_owner   = OWN_PF;
            w_gnt_addr    = pf_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Any in-flight L2 transaction is abandoned; the L2 is reset too.
            r_state      <= S_IDLE;
            r_owner      <= OWN_D;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_l2_addr    <= '0;
            r_l2_wdata   <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_BUSY;
                        r_owner      <= w_gnt_owner;
                        r_l2_read    <= ~w_gnt_write;
                        r_l2_write   <= w_gnt_write;
                        r_l2_addr    <= w_gnt_addr;
                        r_l2_wdata   <= w_gnt_wdata;
                        r_starve_cnt <= w_starve_next;
                    end
                end
                S_BUSY: begin
                    // Command stays up through the l2_resp cycle and drops
                    // on the following edge. Requester inputs are not looked
                    // at here, so nothing in flight can be aborted.
                    if (l2_resp) begin
                        r_state    <= S_GAP;
                        r_l2_read  <= 1'b0;
                        r_l2_write <= 1'b0;
                    end
                end
                S_GAP: begin
                    // Dead cycle: lets the owner drop its level-held request
                    // before the next arbitration sees it.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_l2_read  <= 1'b0;
                    r_l2_write <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic w_busy_resp;

    // l2_resp outside BUSY is ignored.
    assign w_busy_resp = l2_resp && (r_state == S_BUSY);

    assign d_resp  = w_busy_resp && (r_owner == OWN_D);
    assign i_resp  = w_busy_resp && (r_owner == OWN_I);
    assign pf_resp = w_busy_resp && (r_owner == OWN_PF);

    // Read data is broadcast; only the owner's resp qualifies it.
    assign d_rdata  = l2_rdata;
    assign i_rdata  = l2_rdata;
    assign pf_rdata = l2_rdata;

    assign l2_read  = r_l2_read;
    assign l2_write = r_l2_write;
    assign l2_addr  = r_l2_addr;
    assign l2_wdata = r_l2_wdata;

endmodule

// File: tb/tb_l2_port_scheduler.sv
module tb_l2_port_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         d_read, d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         pf_read;
    logic [31:0]  pf_addr;
    logic [255:0] pf_rdata;
    logic         pf_resp;
    logic         l2_read, l2_write;
    logic [31:0]  l2_addr;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    l2_port_scheduler #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] OWN_D = 2'd0, OWN_I = 2'd1, OWN_PF = 2'd2;

    typedef struct {
        logic [1:0]   owner;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           exp_start;   // absolute start cycle, -1 = unchecked
        bit           follow;      // must start 3 cycles after previous l2_resp
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_resp_cyc = -100;
    int lat      = 5;
    bit rsp_en   = 1'b1;
    bit stray_req = 1'b0;

    // Read line the model L2 returns for a given address.
    function automatic logic [255:0] rdfn(input logic [31:0] a);
        if (a == 32'h60) return {32{8'hA5}};
        return {8{~a}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] o, input bit wr, input logic [31:0] a,
                        input logic [255:0] wd, input int st, input bit fol);
        exp_t e;
        e.owner = o; e.wr = wr; e.addr = a; e.wdata = wd; e.exp_start = st; e.follow = fol;
        exp_q.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_l2_read"},  256'(l2_read),  256'd0);
        chk({nm, "_l2_write"}, 256'(l2_write), 256'd0);
        chk({nm, "_l2_addr"},  256'(l2_addr),  256'd0);
        chk({nm, "_l2_wdata"}, l2_wdata,       256'd0);
        chk({nm, "_resps"},    256'({pf_resp, i_resp, d_resp}), 256'd0);
    endtask

    // Wait (bounded) for requester `who` to see its resp, then return just
    // after the next rising edge (the GAP cycle).
    task automatic wait_resp(input int who, input string nm);
        bit got = 1'b0;
        logic [2:0] r;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            r = {pf_resp, i_resp, d_resp};
            if (r[who]) begin got = 1'b1; break; end
        end
        chk({nm, "_resp_seen"}, 256'(got), 256'd1);
        @(posedge clk); #1;
    endtask

    task automatic req_d(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] wd);
        d_write = wr; d_read = rd; d_addr = a; d_wdata = wd;
        wait_resp(0, "d");
        d_write = 1'b0; d_read = 1'b0;
    endtask

    task automatic req_i(input logic [31:0] a);
        i_read = 1'b1; i_addr = a;
        wait_resp(1, "i");
        i_read = 1'b0;
    endtask

    task automatic req_pf(input logic [31:0] a);
        pf_read = 1'b1; pf_addr = a;
        wait_resp(2, "pf");
        pf_read = 1'b0;
    endtask

    // Cycle counter: cycle k is the interval after the k-th rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model L2: responds `lat` cycles into a command, or injects a stray pulse.
    initial begin
        l2_resp = 1'b0;
        l2_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                @(posedge clk); #1;
                l2_resp = 1'b1; l2_rdata = {64{4'h9}};
                @(posedge clk); #1;
                l2_resp = 1'b0; stray_req = 1'b0;
            end else if (rsp_en && !rst && (l2_read || l2_write)) begin
                repeat (lat - 1) @(posedge clk);
                #1;
                l2_resp = 1'b1; l2_rdata = rdfn(l2_addr);
                @(posedge clk); #1;
                l2_resp = 1'b0;
            end
        end
    end

    // Monitor: checks command starts/holds and resp routing against the queue.
    initial begin
        bit prev_cmd = 1'b0;
        bit cmd;
        logic [2:0] got, expv;
        logic [255:0] rd;
        exp_t cur;
        forever begin
            @(negedge clk);
            cmd = l2_read || l2_write;
            if (!rst) begin
                if (cmd && !prev_cmd) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd", 256'(l2_addr), 256'hFFFF_FFFF);
                    end else begin
                        cur = exp_q[0];
                        chk("start_l2_read",  256'(l2_read),  256'(!cur.wr));
                        chk("start_l2_write", 256'(l2_write), 256'(cur.wr));
                        chk("start_l2_addr",  256'(l2_addr),  256'(cur.addr));
                        if (cur.wr) chk("start_l2_wdata", l2_wdata, cur.wdata);
                        if (cur.exp_start >= 0) chk("start_cycle", 256'(cyc), 256'(cur.exp_start));
                        if (cur.follow) chk("start_spacing", 256'(cyc), 256'(last_resp_cyc + 3));
                    end
                end else if (cmd && exp_q.size() > 0) begin
                    chk("hold_l2_addr", 256'(l2_addr), 256'(exp_q[0].addr));
                end

                got = {pf_resp, i_resp, d_resp};
                if (l2_resp && cmd && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    expv = 3'b001 << cur.owner;
                    chk("resp_route", 256'(got), 256'(expv));
                    case (cur.owner)
                        OWN_D:   rd = d_rdata;
                        OWN_I:   rd = i_rdata;
                        default: rd = pf_rdata;
                    endcase
                    chk("resp_rdata", rd, rdfn(cur.addr));
                    last_resp_cyc = cyc;
                end else begin
                    chk("no_resp", 256'(got), 256'd0);
                end
            end
            prev_cmd = cmd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int seen;
        rst = 1'b1;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        i_read = 0; i_addr = '0; pf_read = 0; pf_addr = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst_init");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of BUSY with no l2_resp
        rsp_en = 1'b0;
        push(OWN_I, 0, 32'h80, '0, cyc + 1, 0);
        i_addr = 32'h80; i_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; i_read = 1'b0; i_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst_busy");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        rsp_en = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // Single I read: command cycles 1..5, i_resp at cycle 5
        @(posedge clk); #1;
        lat = 5;
        push(OWN_I, 0, 32'h60, '0, cyc + 1, 0);
        req_i(32'h60);

        // D, I, PF simultaneously -> D, I, PF back to back
        @(posedge clk); #1;
        lat = 3;
        push(OWN_D,  0, 32'h1000, '0, cyc + 1, 0);
        push(OWN_I,  0, 32'h2000, '0, -1, 1);
        push(OWN_PF, 0, 32'h3000, '0, -1, 1);
        fork
            req_d(0, 1, 32'h1000, '0);
            req_i(32'h2000);
            req_pf(32'h3000);
        join

        // D write and D read together: write wins
        @(posedge clk); #1;
        lat = 2;
        push(OWN_D, 1, 32'h100, '1, cyc + 1, 0);
        req_d(1, 1, 32'h100, '1);

        // Starvation guard, limit 2: D D I D D I
        @(posedge clk); #1;
        push(OWN_D, 0, 32'h200, '0, cyc + 1, 0);
        push(OWN_D, 0, 32'h200, '0, -1, 1);
        push(OWN_I, 0, 32'h300, '0, -1, 1);
        push(OWN_D, 0, 32'h200, '0, -1, 1);
        push(OWN_D, 0, 32'h200, '0, -1, 1);
        push(OWN_I, 0, 32'h300, '0, -1, 1);
        d_addr = 32'h200; i_addr = 32'h300;
        d_read = 1'b1; i_read = 1'b1;
        ok = 1'b0; seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (i_resp) seen++;
            if (seen == 2) begin ok = 1'b1; break; end
        end
        chk("starve_two_i_grants", 256'(ok), 256'd1);
        @(posedge clk); #1;
        d_read = 1'b0; i_read = 1'b0;

        // PF in flight: D arrives and d_addr changes during BUSY, no abort
        @(posedge clk); #1;
        lat = 5;
        push(OWN_PF, 0, 32'h400, '0, cyc + 1, 0);
        push(OWN_D,  0, 32'h500, '0, -1, 1);
        fork
            req_pf(32'h400);
            begin
                @(posedge clk); #1;
                d_read = 1'b1; d_addr = 32'h5A0;
                @(posedge clk); #1;
                d_addr = 32'h500;
                wait_resp(0, "d_after_pf");
                d_read = 1'b0;
            end
        join

        // Stray l2_resp while IDLE must not produce any resp
        @(posedge clk); #1;
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Drain the scoreboard
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
